// File: rtl/en_reg_led_bank.sv
`default_nettype none
// ============================================================================
// Module      : en_reg_led_bank
// Description : Enabled multi-mode register (hold / parallel load / shift
//               left / count up) with terminal-count flag, wrap pulse and a
//               per-bit LED indicator drive.
//               Enable is implemented by recirculating the current state
//               through the per-bit next-state mux (no clock gating).
// Ports       : clk_i   - clock, rising-edge active
//               rst_i   - asynchronous active-high reset
//               en_i    - register enable (0 = hold)
//               mode_i  - 00 hold, 01 load, 10 shift left, 11 count up
//               d_i     - parallel load data
//               ser_i   - serial input into bit 0 in shift mode
//               q_o     - register contents
//               ser_o   - bit shifted out of the MSB on the last shift
//               tc_o    - terminal count (combinational)
//               wrap_o  - one-cycle pulse after a count wrap
//               led_o   - LED drive, mirrors q_o when LED_EN = 1
// Revision    : 1.0 - initial release
// ============================================================================
module en_reg_led_bank #(
    parameter int WIDTH     = 8,
    parameter int COUNT_MAX = 2**WIDTH - 1,
    parameter int LED_EN    = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] led_o
);

    localparam logic [1:0] C_MODE_HOLD  = 2'b00;
    localparam logic [1:0] C_MODE_LOAD  = 2'b01;
    localparam logic [1:0] C_MODE_SHIFT = 2'b10;
    localparam logic [1:0] C_MODE_COUNT = 2'b11;

    localparam logic [WIDTH-1:0] C_CNT_MAX = COUNT_MAX[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ser_q;
    logic             ser_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] w_shift_val;
    logic [WIDTH-1:0] w_count_val;
    logic             w_count_wrap;

    // Shift-left value; a 1-bit register simply takes the serial input.
    if (WIDTH == 1) begin : g_shift_w1
        assign w_shift_val = ser_i;
    end else begin : g_shift_wn
        assign w_shift_val = {q_q[WIDTH-2:0], ser_i};
    end

    // ">=" also catches a value above the terminal count (reachable via a
    // load), which must wrap straight to zero on the next count.
    assign w_count_wrap = (q_q >= C_CNT_MAX);
    assign w_count_val  = w_count_wrap ? '0 : (q_q + WIDTH'(1));

    // Per-bit next-state mux; en_i = 0 recirculates the current state.
    always_comb begin
        q_d    = q_q;
        ser_d  = ser_q;
        wrap_d = 1'b0;
        if (en_i) begin
            case (mode_i)
                C_MODE_HOLD: begin
                    q_d = q_q;
                end
                C_MODE_LOAD: begin
                    q_d = d_i;
                end
                C_MODE_SHIFT: begin
                    q_d   = w_shift_val;
                    ser_d = q_q[WIDTH-1];
                end
                C_MODE_COUNT: begin
                    q_d    = w_count_val;
                    wrap_d = w_count_wrap;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q    <= '0;
            ser_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ser_q  <= ser_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = q_q;
    assign ser_o  = ser_q;
    assign wrap_o = wrap_q;
    assign tc_o   = en_i && (mode_i == C_MODE_COUNT) && (q_q == C_CNT_MAX);

    // LED drive is output-only; nothing reads it back into state.
    if (LED_EN != 0) begin : g_led_on
        assign led_o = q_q;
    end else begin : g_led_off
        assign led_o = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_en_reg_led_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_en_reg_led_bank
// Description : Directed self-checking bench for en_reg_led_bank.
//               dut4 : WIDTH=4, COUNT_MAX=9, LED_EN=1
//               dutn : WIDTH=4, COUNT_MAX=9, LED_EN=0 (shares dut4 inputs)
//               dut1 : WIDTH=1, COUNT_MAX=1, LED_EN=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_en_reg_led_bank;

    logic       clk;
    logic       rst;

    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       ser;
    logic [3:0] q4;
    logic       sero4;
    logic       tc4;
    logic       wrap4;
    logic [3:0] led4;

    logic [3:0] qn;
    logic       seron;
    logic       tcn;
    logic       wrapn;
    logic [3:0] ledn;

    logic       en1;
    logic [1:0] mode1;
    logic       d1;
    logic       ser1;
    logic       q1;
    logic       sero1;
    logic       tc1;
    logic       wrap1;
    logic       led1;

    int checks;
    int errors;

    en_reg_led_bank #(.WIDTH(4), .COUNT_MAX(9), .LED_EN(1)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .d_i(d),
        .ser_i(ser), .q_o(q4), .ser_o(sero4), .tc_o(tc4), .wrap_o(wrap4),
        .led_o(led4)
    );

    en_reg_led_bank #(.WIDTH(4), .COUNT_MAX(9), .LED_EN(0)) dutn (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .d_i(d),
        .ser_i(ser), .q_o(qn), .ser_o(seron), .tc_o(tcn), .wrap_o(wrapn),
        .led_o(ledn)
    );

    en_reg_led_bank #(.WIDTH(1), .COUNT_MAX(1), .LED_EN(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en1), .mode_i(mode1), .d_i(d1),
        .ser_i(ser1), .q_o(q1), .ser_o(sero1), .tc_o(tc1), .wrap_o(wrap1),
        .led_o(led1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [3:0] val);
        en   = 1'b1;
        mode = 2'b01;
        d    = val;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1; mode = 2'b11; d = 4'h0; ser = 1'b0;
        en1 = 1'b0; mode1 = 2'b00; d1 = 1'b0; ser1 = 1'b0;
        #1;
        checks++;
        if (q4 !== 4'h0) begin errors++; $display("FAIL reset_q got %h exp %h", q4, 4'h0); end
        checks++;
        if (sero4 !== 1'b0) begin errors++; $display("FAIL reset_ser got %b exp 0", sero4); end
        checks++;
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap4); end
        checks++;
        if (led4 !== 4'h0) begin errors++; $display("FAIL reset_led got %h exp 0", led4); end
        checks++;
        if (tc4 !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc4); end
        // Reset held across a clock edge keeps the register at zero.
        step();
        checks++;
        if (q4 !== 4'h0) begin errors++; $display("FAIL reset_hold_q got %h exp 0", q4); end
        rst = 1'b0;
        mode = 2'b00;
        step();
    endtask

    task automatic test_load_and_enable();
        load4(4'hA);
        checks++;
        if (q4 !== 4'hA) begin errors++; $display("FAIL load_q got %h exp %h", q4, 4'hA); end
        checks++;
        if (led4 !== 4'hA) begin errors++; $display("FAIL load_led got %h exp %h", led4, 4'hA); end
        checks++;
        if (ledn !== 4'h0) begin errors++; $display("FAIL led_disabled got %h exp 0", ledn); end
        checks++;
        if (qn !== 4'hA) begin errors++; $display("FAIL load_q_noled got %h exp %h", qn, 4'hA); end
        en = 1'b0; mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q4 !== 4'hA) begin errors++; $display("FAIL en_hold_q[%0d] got %h exp %h", i, q4, 4'hA); end
        end
        checks++;
        if (tc4 !== 1'b0) begin errors++; $display("FAIL en_off_tc got %b exp 0", tc4); end
    endtask

    task automatic test_count_wrap();
        load4(4'h8);
        mode = 2'b11;
        checks++;
        if (tc4 !== 1'b0) begin errors++; $display("FAIL tc_at8 got %b exp 0", tc4); end
        step();
        checks++;
        if (q4 !== 4'h9) begin errors++; $display("FAIL count_to9 got %h exp 9", q4); end
        checks++;
        if (tc4 !== 1'b1) begin errors++; $display("FAIL tc_at9 got %b exp 1", tc4); end
        checks++;
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL wrap_at9 got %b exp 0", wrap4); end
        step();
        checks++;
        if (q4 !== 4'h0) begin errors++; $display("FAIL count_wrap_q got %h exp 0", q4); end
        checks++;
        if (wrap4 !== 1'b1) begin errors++; $display("FAIL count_wrap_pulse got %b exp 1", wrap4); end
        step();
        checks++;
        if (q4 !== 4'h1) begin errors++; $display("FAIL count_after_wrap got %h exp 1", q4); end
        checks++;
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL wrap_clear got %b exp 0", wrap4); end
        // Wrap followed by a disabled cycle: pulse must drop, value holds.
        load4(4'h9);
        mode = 2'b11;
        step();
        en = 1'b0;
        step();
        checks++;
        if (wrap4 !== 1'b0 || q4 !== 4'h0) begin
            errors++; $display("FAIL wrap_en_off got wrap=%b q=%h exp wrap=0 q=0", wrap4, q4);
        end
    endtask

    task automatic test_out_of_range();
        load4(4'hC);
        mode = 2'b11;
        checks++;
        if (tc4 !== 1'b0) begin errors++; $display("FAIL tc_atC got %b exp 0", tc4); end
        step();
        checks++;
        if (q4 !== 4'h0 || wrap4 !== 1'b1) begin
            errors++; $display("FAIL oor_wrap got q=%h wrap=%b exp q=0 wrap=1", q4, wrap4);
        end
        mode = 2'b00;
        step();
        checks++;
        if (q4 !== 4'h0 || wrap4 !== 1'b0) begin
            errors++; $display("FAIL hold_after_oor got q=%h wrap=%b exp q=0 wrap=0", q4, wrap4);
        end
    endtask

    task automatic test_shift();
        logic [3:0] sin;
        logic [3:0] sexp;
        sin  = 4'b1011;   // applied MSB first: 1,0,1,1
        sexp = 4'b1001;   // expected ser_o sequence MSB first: 1,0,0,1
        load4(4'h9);
        mode = 2'b10;
        for (int i = 3; i >= 0; i--) begin
            ser = sin[i];
            step();
            checks++;
            if (sero4 !== sexp[i]) begin
                errors++; $display("FAIL shift_ser[%0d] got %b exp %b", 3 - i, sero4, sexp[i]);
            end
        end
        checks++;
        if (q4 !== 4'hB) begin errors++; $display("FAIL shift_final_q got %h exp %h", q4, 4'hB); end
        // ser_o holds during load and count modes.
        load4(4'h2);
        checks++;
        if (sero4 !== 1'b1) begin errors++; $display("FAIL ser_hold_load got %b exp 1", sero4); end
    endtask

    task automatic test_async_reset();
        load4(4'h7);
        en = 1'b1; mode = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q4 !== 4'h0 || led4 !== 4'h0) begin
            errors++; $display("FAIL async_rst got q=%h led=%h exp q=0 led=0", q4, led4);
        end
        checks++;
        if (sero4 !== 1'b0) begin errors++; $display("FAIL async_rst_ser got %b exp 0", sero4); end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (q4 !== 4'h1) begin errors++; $display("FAIL post_rst_count got %h exp 1", q4); end
        mode = 2'b00;
    endtask

    task automatic test_width1();
        en1 = 1'b1; mode1 = 2'b11;
        checks++;
        if (q1 !== 1'b0 || tc1 !== 1'b0) begin
            errors++; $display("FAIL w1_start got q=%b tc=%b exp q=0 tc=0", q1, tc1);
        end
        step();
        checks++;
        if (q1 !== 1'b1 || wrap1 !== 1'b0 || tc1 !== 1'b1) begin
            errors++; $display("FAIL w1_cnt1 got q=%b wrap=%b tc=%b exp 1 0 1", q1, wrap1, tc1);
        end
        checks++;
        if (led1 !== 1'b1) begin errors++; $display("FAIL w1_led got %b exp 1", led1); end
        step();
        checks++;
        if (q1 !== 1'b0 || wrap1 !== 1'b1) begin
            errors++; $display("FAIL w1_wrap got q=%b wrap=%b exp q=0 wrap=1", q1, wrap1);
        end
        step();
        checks++;
        if (q1 !== 1'b1 || wrap1 !== 1'b0) begin
            errors++; $display("FAIL w1_cnt2 got q=%b wrap=%b exp q=1 wrap=0", q1, wrap1);
        end
        mode1 = 2'b10; ser1 = 1'b0;
        step();
        checks++;
        if (q1 !== 1'b0 || sero1 !== 1'b1) begin
            errors++; $display("FAIL w1_shift0 got q=%b ser=%b exp q=0 ser=1", q1, sero1);
        end
        ser1 = 1'b1;
        step();
        checks++;
        if (q1 !== 1'b1 || sero1 !== 1'b0) begin
            errors++; $display("FAIL w1_shift1 got q=%b ser=%b exp q=1 ser=0", q1, sero1);
        end
        en1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_and_enable();
        test_count_wrap();
        test_out_of_range();
        test_shift();
        test_async_reset();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/en_reg_led_bank.md
EN_REG_LED_BANK -- requirements
Module: en_reg_led_bank

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 1..16.
REQ-002 Parameter COUNT_MAX, default 2**WIDTH-1, terminal count value for count mode; legal range 1..2**WIDTH-1.
REQ-003 Parameter LED_EN, default 1, 1 = per-bit LED indicator drive instantiated, 0 = led_o tied low.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 en_i  input  1  register enable; 0 = hold regardless of mode_i.
REQ-007 mode_i  input  2  00 hold, 01 parallel load, 10 shift left, 11 count up.
REQ-008 d_i  input  WIDTH  parallel load data.
REQ-009 ser_i  input  1  serial input shifted into bit 0 in shift mode.
REQ-010 q_o  output  WIDTH  register contents.
REQ-011 ser_o  output  1  registered bit WIDTH-1 shifted out on last shift.
REQ-012 tc_o  output  1  terminal count: high while q_o == COUNT_MAX and mode_i == 11 and en_i == 1 (combinational).
REQ-013 wrap_o  output  1  registered one-cycle pulse after a count wrap.
REQ-014 led_o  output  WIDTH  per-bit LED drive, equal to q_o when LED_EN = 1.

Function
REQ-015 The register SHALL update only on rising clk_i edges with en_i = 1; with en_i = 0, q_o, ser_o SHALL hold and wrap_o SHALL be 0 next cycle.
REQ-016 Mode 00 SHALL hold q_o and ser_o; wrap_o SHALL be 0 next cycle.
REQ-017 Mode 01 SHALL load q_o <= d_i in one cycle (latency 1); ser_o held.
REQ-018 Mode 10 SHALL set q_o <= {q_o[WIDTH-2:0], ser_i} and ser_o <= q_o[WIDTH-1]; for WIDTH = 1, q_o <= ser_i.
REQ-019 Mode 11 SHALL set q_o <= q_o + 1 when q_o < COUNT_MAX, else q_o <= 0 and wrap_o <= 1 for exactly one cycle.
REQ-020 If q_o > COUNT_MAX when count mode is entered (possible after load), next count SHALL wrap to 0 and assert wrap_o.
REQ-021 Count arithmetic SHALL be modulo COUNT_MAX+1 with no carry beyond WIDTH bits; ser_o held in count mode.
REQ-022 wrap_o SHALL be 0 in every cycle not immediately following a wrap.
REQ-023 Mode change and en_i change SHALL take effect on the same edge they are sampled; no pipeline stage between inputs and q_o.
REQ-024 led_o SHALL track q_o with zero additional latency; LED drive is output-only and SHALL NOT feed back into state.
REQ-025 The block SHALL be built from 2:1 mux per bit feeding a DFF per bit (enable-by-recirculation), not clock gating.

Reset
REQ-026 rst_i high SHALL asynchronously force q_o = 0, ser_o = 0, wrap_o = 0, led_o = 0 without waiting for clk_i.
REQ-027 During reset tc_o SHALL be 0 unless COUNT_MAX comparison with 0 applies (COUNT_MAX >= 1, so tc_o = 0).
REQ-028 Reset asserted mid-count or mid-shift SHALL discard the operation; first edge after rst_i falls SHALL apply current en_i/mode_i to q_o = 0.

Verification (WIDTH = 4, COUNT_MAX = 9 unless noted)
REQ-029 Load: en_i=1, mode 01, d_i=0xA -> q_o=0xA, led_o=0xA after 1 edge; then en_i=0, mode 11, 3 edges -> q_o stays 0xA.
REQ-030 Count wrap: from q_o=8, mode 11 -> 9 with tc_o=1, next edge q_o=0, wrap_o=1 one cycle, following edge q_o=1, wrap_o=0.
REQ-031 Out-of-range count: load 0xC, then mode 11 -> q_o=0, wrap_o=1.
REQ-032 Shift: load 0x9, mode 10, ser_i=1,0,1,1 over 4 edges -> ser_o sequence 1,0,0,1; final q_o=0xB.
REQ-033 Async reset: q_o=0x7, assert rst_i between edges -> q_o=0, led_o=0 immediately; deassert, mode 11 -> q_o=1 after 1 edge.
REQ-034 WIDTH=1, COUNT_MAX=1: mode 11 toggles q_o 0,1,0 with wrap_o on each 1->0; mode 10 ser_i=1 -> q_o=1, ser_o=previous q_o.
